// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction in flight; alternating grant under contention; response timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_ls_q, last_ls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pick_ls;
  logic pick_if;
  logic idle;
  logic busy;
  logic done;
  logic tmo;

  // Arbitration and command forwarding; LS wins unless it won last time.
  always_comb begin
    idle      = rstn && (state_q == IDLE);
    pick_ls   = ls_req && !(last_ls_q && if_req);
    pick_if   = if_req && !pick_ls;
    if_gnt    = idle && pick_if;
    ls_gnt    = idle && pick_ls;
    mem_req   = if_gnt || ls_gnt;
    mem_we    = pick_ls ? ls_we : 1'b0;
    mem_be    = pick_ls ? ls_be : {BE_W{1'b1}};
    mem_addr  = pick_ls ? ls_addr : if_addr;
    mem_wdata = ls_wdata;
  end

  // Completion / timeout decode routed to the owner of the transaction.
  always_comb begin
    busy      = rstn && (state_q != IDLE);
    done      = busy && mem_rvalid;
    tmo       = busy && !mem_rvalid && (cnt_q == CNT_LAST);
    if_rvalid = done && (state_q == BUSY_IF);
    ls_rvalid = done && (state_q == BUSY_LS);
    if_err    = tmo && (state_q == BUSY_IF);
    ls_err    = tmo && (state_q == BUSY_LS);
    if_rdata  = mem_rdata;
    ls_rdata  = mem_rdata;
  end

  // Next-state logic for the FSM, owner history and timeout counter.
  always_comb begin
    state_d   = state_q;
    last_ls_d = last_ls_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          state_d   = pick_ls ? BUSY_LS : BUSY_IF;
          last_ls_d = pick_ls;
          cnt_d     = '0;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (!mem_rvalid) cnt_d = cnt_q + 1'b1;
        if (mem_rvalid || (cnt_q == CNT_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      last_ls_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_ls_q <= last_ls_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Stimulus pushes expected events by cycle; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags: {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, mem_req}
  localparam logic [6:0] F_IFG = 7'b1000001;
  localparam logic [6:0] F_LSG = 7'b0100001;
  localparam logic [6:0] F_IFV = 7'b0010000;
  localparam logic [6:0] F_LSV = 7'b0001000;
  localparam logic [6:0] F_IFE = 7'b0000100;

  typedef struct {
    int          c;
    logic [6:0]  f;
    bit          cmd;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    bit          wd;
    logic [31:0] wdata;
    bit          rd;
    logic [31:0] rdata;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  task automatic push(input string nm, input int c, input logic [6:0] f,
                      input bit cmd, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input bit wd,
                      input logic [31:0] wdata, input bit rd,
                      input logic [31:0] rdata);
    exp_t e;
    e.nm = nm; e.c = c; e.f = f; e.cmd = cmd; e.we = we; e.be = be;
    e.addr = addr; e.wd = wd; e.wdata = wdata; e.rd = rd; e.rdata = rdata;
    q.push_back(e);
  endtask

  task automatic exp_gnt(input string nm, input int c, input bit is_ls,
                         input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input bit wd,
                         input logic [31:0] wdata);
    push(nm, c, is_ls ? F_LSG : F_IFG, 1'b1, we, be, addr, wd, wdata,
         1'b0, 32'h0);
  endtask

  task automatic exp_rsp(input string nm, input int c, input bit is_ls,
                         input logic [31:0] rdata);
    push(nm, c, is_ls ? F_LSV : F_IFV, 1'b0, 1'b0, 4'h0, 32'h0,
         1'b0, 32'h0, 1'b1, rdata);
  endtask

  // Monitor: any active output must match the next scoreboard entry.
  always @(negedge clk) begin : mon
    logic [6:0]  f;
    logic [31:0] rd_act;
    exp_t        e;
    bit          ok;
    if (mon_on) begin
      f = {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, mem_req};
      while (q.size() > 0 && q[0].c < cyc) begin
        e = q.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL %s: cycle %0d got no event, required flags %b",
                 e.nm, e.c, e.f);
      end
      if (f != 7'b0) begin
        if (q.size() == 0 || q[0].c != cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected: cycle %0d got flags %b, required none",
                   cyc, f);
        end else begin
          e = q.pop_front();
          n_chk++;
          rd_act = if_rvalid ? if_rdata : ls_rdata;
          ok = (f == e.f);
          if (e.cmd)
            ok = ok && mem_we == e.we && mem_be == e.be && mem_addr == e.addr;
          if (e.wd) ok = ok && mem_wdata == e.wdata;
          if (e.rd) ok = ok && rd_act == e.rdata;
          if (!ok) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got f=%b we=%b be=%h a=%h wd=%h rd=%h, required f=%b we=%b be=%h a=%h wd=%h rd=%h",
                     e.nm, cyc, f, mem_we, mem_be, mem_addr, mem_wdata, rd_act,
                     e.f, e.we, e.be, e.addr, e.wdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    logic [6:0] f;
    @(negedge clk);
    f = {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, mem_req};
    n_chk++;
    if (f != 7'b0) begin
      n_fail++;
      $display("FAIL %s: got flags %b, required 0000000", nm, f);
    end
  endtask

  int g;

  initial begin
    rstn = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    mon_on = 1'b1;
    tick();
    tick();
    if_req = 1'b1; ls_req = 1'b1; mem_rvalid = 1'b1;
    chk_quiet("reset_outputs_a");
    tick();
    chk_quiet("reset_outputs_b");
    tick();
    rstn = 1'b1; if_req = 1'b0; ls_req = 1'b0; mem_rvalid = 1'b0;
    chk_quiet("post_reset_idle");

    // Lone fetch
    tick();
    if_req = 1'b1; if_addr = 32'h100;
    exp_gnt("fetch_gnt", cyc, 1'b0, 1'b0, 4'hF, 32'h100, 1'b0, 32'h0);
    tick();
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    exp_rsp("fetch_rsp", cyc, 1'b0, 32'hDEADBEEF);
    tick();
    mem_rvalid = 1'b0;

    // Contention after reset: LS, IF, LS, IF two cycles apart
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_rvalid = 1'b0; if_req = 1'b1; ls_req = 1'b1;
      ls_we = 1'b0; ls_be = 4'hF; ls_wdata = 32'h0;
      if_addr = 32'h300 + 32'(i * 16);
      ls_addr = 32'h400 + 32'(i * 16);
      if (i % 2 == 0)
        exp_gnt("contend_ls_gnt", cyc, 1'b1, 1'b0, 4'hF, ls_addr, 1'b0, 32'h0);
      else
        exp_gnt("contend_if_gnt", cyc, 1'b0, 1'b0, 4'hF, if_addr, 1'b0, 32'h0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1000 + 32'(i);
      exp_rsp("contend_rsp", cyc, (i % 2 == 0), 32'h1000 + 32'(i));
    end
    tick();
    if_req = 1'b0; ls_req = 1'b0; mem_rvalid = 1'b0;

    // Store mirrored onto memory port; fetch held during busy
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h3;
    ls_addr = 32'h204; ls_wdata = 32'h1234;
    exp_gnt("store_gnt", cyc, 1'b1, 1'b1, 4'h3, 32'h204, 1'b1, 32'h1234);
    tick();
    ls_req = 1'b0; ls_we = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    exp_rsp("store_ack", cyc, 1'b1, 32'h0);
    tick();
    mem_rvalid = 1'b0;
    g = cyc;
    exp_gnt("held_fetch_gnt", g, 1'b0, 1'b0, 4'hF, 32'h500, 1'b0, 32'h0);
    push("fetch_timeout", g + 15, F_IFE, 1'b0, 1'b0, 4'h0, 32'h0,
         1'b0, 32'h0, 1'b0, 32'h0);

    // Silent memory: error 15 cycles after grant, regrant next cycle
    tick();
    if_req = 1'b0;
    repeat (14) tick();
    tick();
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h600;
    exp_gnt("regrant_ls", cyc, 1'b1, 1'b0, 4'hF, 32'h600, 1'b0, 32'h0);

    // Reset mid-transaction, then stray completion
    tick();
    ls_req = 1'b0; rstn = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    chk_quiet("reset_mid_txn");
    tick();
    rstn = 1'b1;
    chk_quiet("stray_rvalid");
    tick();
    mem_rvalid = 1'b0; if_req = 1'b1; ls_req = 1'b1;
    if_addr = 32'h800; ls_addr = 32'h900;
    exp_gnt("post_reset_ls_gnt", cyc, 1'b1, 1'b0, 4'hF, 32'h900, 1'b0, 32'h0);
    tick();
    if_req = 1'b0; ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA;
    exp_rsp("post_reset_ls_rsp", cyc, 1'b1, 32'h55AA);
    tick();
    mem_rvalid = 1'b0;

    // Completion on the timeout cycle wins over error
    tick();
    if_req = 1'b1; if_addr = 32'h700;
    g = cyc;
    exp_gnt("late_fetch_gnt", g, 1'b0, 1'b0, 4'hF, 32'h700, 1'b0, 32'h0);
    exp_rsp("late_fetch_rsp", g + 15, 1'b0, 32'hCAFEF00D);
    tick();
    if_req = 1'b0;
    repeat (13) tick();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;

    // Completion while idle is ignored
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    chk_quiet("idle_rvalid");
    tick();
    mem_rvalid = 1'b0;
    chk_quiet("idle_after_rvalid");

    repeat (3) tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
